// File: rtl/pipeline_3_memory_pkg.sv
// Shared definitions for the memory pipeline stage: control-word bit
// positions, branch condition codes, flag layout and FSM state encoding.
package pipeline_pkg;

  localparam int CTRL_W    = 22;
  localparam int ALUOP_HI  = 7;
  localparam int ALUOP_LO  = 6;
  localparam int SET_FLAGS = 11;
  localparam int MEM_WRITE = 12;
  localparam int MEM_READ  = 13;

  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_AL   = 3'b001;
  localparam logic [2:0] COND_EQ   = 3'b010;
  localparam logic [2:0] COND_NE   = 3'b011;
  localparam logic [2:0] COND_LT   = 3'b100;
  localparam logic [2:0] COND_LE   = 3'b101;

  // Flag vector layout is {N, V, Z}
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [5:0] INST_BUBBLE = 6'd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/pipeline_3_memory_flag_unit.sv
// Combinational flag evaluation: next {N,V,Z} from the retiring result and
// the branch decision taken against the currently held flags.
module flag_unit
  import pipeline_pkg::*;
(
  input  logic [15:0] i_result,
  input  logic        i_sign_a,
  input  logic        i_sign_b,
  input  logic [1:0]  i_aluop,
  input  logic [2:0]  i_cond,
  input  logic [2:0]  i_flags,
  output logic [2:0]  o_flags_next,
  output logic        o_cond_true
);

  logic w_n;
  logic w_v;
  logic w_z;
  logic w_lt;

  // Next flags; overflow only meaningful for subtract (A - B)
  always_comb begin
    w_n          = i_result[15];
    w_z          = ~|i_result;
    w_v          = (i_aluop == ALUOP_SUB) && (i_sign_a != i_sign_b) &&
                   (i_result[15] != i_sign_a);
    o_flags_next = {w_n, w_v, w_z};
  end

  // Branch decision uses the flags as they stand before this retire
  always_comb begin
    o_cond_true = 1'b0;
    w_lt        = i_flags[FLAG_N] ^ i_flags[FLAG_V];
    case (i_cond)
      COND_AL: o_cond_true = 1'b1;
      COND_EQ: o_cond_true = i_flags[FLAG_Z];
      COND_NE: o_cond_true = !i_flags[FLAG_Z];
      COND_LT: o_cond_true = w_lt;
      COND_LE: o_cond_true = w_lt | i_flags[FLAG_Z];
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_3_memory.sv
// Memory pipeline stage: holds one instruction from execute, performs its
// data-memory access over a req/ready handshake (stalling upstream while
// waiting), maintains N/V/Z, resolves delayed branches and drives write-back.
module pipeline_3_memory
  import pipeline_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [15:0] RDATA_ERR   = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] control_in,
  input  logic [15:0] data_Rd_in,
  input  logic [15:0] result_in,
  input  logic        highbit_shifted_Rm_in,
  input  logic        highbit_data_Rn_in,
  input  logic [5:0]  inst_type_in,
  input  logic [15:0] delayed_B_in,
  input  logic [2:0]  delayed_cond_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_err,
  output logic [21:0] control_out,
  output logic [5:0]  inst_type_out,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  flags_out,
  output logic        branch_taken,
  output logic [15:0] branch_target
);

  localparam logic [15:0] TMO_LIM = 16'(MEM_TIMEOUT);
  localparam logic        TMO_EN  = (MEM_TIMEOUT != 0);

  // Entry register S
  logic        r_valid;
  logic [21:0] r_control;
  logic [15:0] r_data_rd;
  logic [15:0] r_result;
  logic        r_sign_rm;
  logic        r_sign_rn;
  logic [5:0]  r_inst_type;
  logic [15:0] r_delayed_b;
  logic [2:0]  r_delayed_cond;

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  logic [15:0] r_tmo_cnt;
  logic [15:0] r_rdata_q;
  logic [2:0]  r_flags;

  logic        w_capture;
  logic        w_in_access;
  logic        w_mem_op;
  logic        w_in_mem_op;
  logic        w_timeout;
  logic        w_retire;
  logic [2:0]  w_flags_next;
  logic        w_cond_true;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_capture   = !w_in_access;
  assign w_mem_op    = r_control[MEM_READ] | r_control[MEM_WRITE];
  assign w_in_mem_op = (inst_type_in != INST_BUBBLE) &&
                       (control_in[MEM_READ] || control_in[MEM_WRITE]);
  // A ready in the same cycle always beats the timeout
  assign w_timeout   = w_in_access && !mem_ready && TMO_EN &&
                       ((r_tmo_cnt + 16'd1) == TMO_LIM);
  assign w_retire    = r_valid && (!w_mem_op || (r_state == ST_COMPLETE));

  flag_unit u_flag_unit (
    .i_result     (r_result),
    .i_sign_a     (r_sign_rn),
    .i_sign_b     (r_sign_rm),
    .i_aluop      (r_control[ALUOP_HI:ALUOP_LO]),
    .i_cond       (r_delayed_cond),
    .i_flags      (r_flags),
    .o_flags_next (w_flags_next),
    .o_cond_true  (w_cond_true)
  );

  // Capture the execute-stage outputs whenever not stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid        <= 1'b0;
      r_control      <= '0;
      r_data_rd      <= '0;
      r_result       <= '0;
      r_sign_rm      <= 1'b0;
      r_sign_rn      <= 1'b0;
      r_inst_type    <= '0;
      r_delayed_b    <= '0;
      r_delayed_cond <= '0;
    end else if (w_capture) begin
      r_valid        <= (inst_type_in != INST_BUBBLE);
      r_control      <= control_in;
      r_data_rd      <= data_Rd_in;
      r_result       <= result_in;
      r_sign_rm      <= highbit_shifted_Rm_in;
      r_sign_rn      <= highbit_data_Rn_in;
      r_inst_type    <= inst_type_in;
      r_delayed_b    <= delayed_B_in;
      r_delayed_cond <= delayed_cond_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and memory-side outputs
  always_comb begin
    w_state_nxt = r_state;
    stall_out   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_err     = 1'b0;
    if (r_state == ST_ACCESS) begin
      stall_out = 1'b1;
      mem_req   = 1'b1;
      mem_we    = r_control[MEM_WRITE];
      mem_addr  = r_result;
      mem_wdata = r_data_rd;
      mem_err   = w_timeout;
      if (mem_ready || w_timeout) w_state_nxt = ST_COMPLETE;
    end else begin
      w_state_nxt = w_in_mem_op ? ST_ACCESS : ST_IDLE;
    end
  end

  // Timeout counter runs only while waiting inside ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          r_tmo_cnt <= '0;
    else if (w_in_access && w_state_nxt == ST_ACCESS)  r_tmo_cnt <= r_tmo_cnt + 16'd1;
    else                                               r_tmo_cnt <= '0;
  end

  // Read data (or the error pattern) held for write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_rdata_q <= '0;
    else if (w_in_access && mem_ready) r_rdata_q <= mem_rdata;
    else if (w_timeout)                r_rdata_q <= RDATA_ERR;
  end

  // Status flags update on the retire edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_flags <= '0;
    else if (w_retire && r_control[SET_FLAGS]) r_flags <= w_flags_next;
  end

  assign control_out   = r_control;
  assign inst_type_out = r_inst_type;
  assign wb_valid      = w_retire && !r_control[MEM_WRITE];
  assign wb_data       = r_control[MEM_READ] ? r_rdata_q : r_result;
  assign flags_out     = r_flags;
  assign branch_taken  = w_retire && w_cond_true;
  assign branch_target = r_delayed_b;

endmodule
